wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Shares the single register-file write port among the functional-unit writeback sources: INT, FP, MEM and CTRL, indexed by FuncUnitType_t values 0-3.
- Each cycle, one pending writeback is chosen round-robin and captured into a one-entry output register.
- The registered write is presented to the register file.
- On acceptance, the block pulses a scoreboard release for the owning reservation ID.
- Sits between the functional-unit result stages and the vector register file / scoreboard.

Parameters:
- NUM_REQ, 4, number of writeback requesters; index equals FuncUnitType_t value.
- DATA_W, `VEC_WIDTH*`DWIDTH (512), width of one Vector_t.
- STAT_W, 32, statistics counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a writeback pending
- req_ready  out  NUM_REQ  requester i accepted this cycle
- req_reg  in  NUM_REQ*`RF_REG_BITS  GRegIdx_t destination, per requester
- req_data  in  NUM_REQ*DATA_W  Vector_t result, per requester
- req_mask  in  NUM_REQ*`VEC_WIDTH  Mask_t lane write enables
- req_rsv  in  NUM_REQ*5  RsvID_t of the producing instruction
- wb_valid  out  1  output register holds a write
- wb_ready  in  1  register file accepts the write
- wb_reg  out  `RF_REG_BITS  destination register
- wb_data  out  DATA_W  write data
- wb_mask  out  `VEC_WIDTH  lane enables
- sb_release  out  1  one-cycle pulse: scoreboard entry freed
- sb_rsv_id  out  5  RsvID_t being released

Behaviour:
- Reset (synchronous, active-high): wb_valid=0, sb_release=0, wb_reg/wb_data/wb_mask/sb_rsv_id=0, priority pointer=0 (INT highest). Reset mid-transfer discards the held write; no release is issued for it.
- Grant, combinational: the first i with req_valid[i], searching from the pointer upward modulo NUM_REQ. At most one grant per cycle.
- Load enable: load = (!wb_valid || wb_ready).
- req_ready[i] = grant[i] && load. Every other req_ready bit is 0.
- Transfer on req_valid[i] && req_ready[i]: the requester's reg/data/mask/rsv are captured into the output register next cycle; wb_valid=1 next cycle.
- Latency: one cycle from requester accept to wb_valid.
- Full throughput: a new capture may occur in the same cycle the held write drains (wb_ready=1).
- Drain without refill: if wb_valid && wb_ready and no grant, wb_valid goes to 0 next cycle.
- Hold: wb_valid && !wb_ready keeps all wb_* outputs stable and drives req_ready=0 on every requester.
- Pointer update: on each accepted transfer, pointer <= (granted index + 1) mod NUM_REQ. Unchanged otherwise.
- Release: sb_release = wb_valid && wb_ready, combinational, with sb_rsv_id = the held rsv. Exactly one pulse per write.
- Zero mask: an all-zero mask is still forwarded and still releases its scoreboard entry.
- Requester rule: a requester must not drop req_valid or change its payload while req_ready=0.
- Assertions: at most one req_ready bit set; wb_* stable while wb_valid && !wb_ready.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- When defined, add outputs stat_grants (NUM_REQ*STAT_W) and stat_stalls (NUM_REQ*STAT_W).
  - Grant counter i increments on each accepted transfer from requester i.
  - Stall counter i increments each cycle req_valid[i] && !req_ready[i].
  - Both counters saturate at all-ones and clear on rst.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Add to gDefine:
  - `WB_NUM_REQ
  - typedef WbReq_t, a struct of GRegIdx_t reg, Vector_t data, Mask_t mask, RsvID_t rsv
- Reuse FuncUnitType_t as the requester index.
- One natural sub-module: rr_arbiter (parameterised N; inputs req and pointer, output one-hot grant plus encoded index). It is reused later by the issue stage.

Test Plan:
- Single INT request, reg=5, mask=16'hFFFF, rsv=3, wb_ready=1 -> wb_valid next cycle with reg 5; sb_release=1 with sb_rsv_id=3 that same cycle; pointer becomes 1.
- All four requesters held valid, wb_ready=1 -> grants in order INT, FP, MEM, CTRL on consecutive cycles, then INT again. Exactly one req_ready bit per cycle.
- wb_ready=0 for 3 cycles with a write held -> wb_* stable, all req_ready=0, no sb_release. wb_ready=1 -> release pulse, and a pending FP request is captured in the same cycle.
- Pointer at 2; MEM and INT both valid -> MEM granted first, INT next.
- rst asserted while wb_valid=1 and wb_ready=0 -> next cycle wb_valid=0, pointer=0, no sb_release ever for the dropped write.
- WB_ARB_STATS_EN: FP request stalled 4 cycles then accepted -> stat_stalls[FP]=4, stat_grants[FP]=1. Preload a counter to all-ones -> it stays all-ones.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: requester indices, register/vector types and the WbReq_t payload.
// Provides defaults for the global width macros when the surrounding build does not define them.
`ifndef VEC_WIDTH
`define VEC_WIDTH 16
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef RF_REG_BITS
`define RF_REG_BITS 6
`endif
`ifndef WB_NUM_REQ
`define WB_NUM_REQ 4
`endif

package wb_arbiter_pkg;

  localparam int VecWidth = `VEC_WIDTH;
  localparam int DataW    = `VEC_WIDTH * `DWIDTH;
  localparam int RegBits  = `RF_REG_BITS;
  localparam int RsvBits  = 5;

  typedef enum logic [1:0] {
    FU_INT  = 2'd0,
    FU_FP   = 2'd1,
    FU_MEM  = 2'd2,
    FU_CTRL = 2'd3
  } FuncUnitType_t;

  typedef logic [RegBits-1:0]  GRegIdx_t;
  typedef logic [DataW-1:0]    Vector_t;
  typedef logic [VecWidth-1:0] Mask_t;
  typedef logic [RsvBits-1:0]  RsvID_t;

  typedef struct packed {
    GRegIdx_t regIdx;
    Vector_t  data;
    Mask_t    mask;
    RsvID_t   rsv;
  } WbReq_t;

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above the pointer, wrapping modulo N.
// Requires N >= 2; also used by the issue stage.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] gntIdx,
  output logic            gntValid
);

  int idx;

  always_comb begin
    grant    = '0;
    gntIdx   = '0;
    gntValid = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gntValid && req[idx]) begin
        grant[idx] = 1'b1;
        gntIdx     = IdxW'(idx);
        gntValid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter feeding a one-entry output register to the register file write port.
// Define WB_ARB_STATS_EN to add per-requester grant and stall counters.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = `WB_NUM_REQ,
  parameter int DATA_W  = DataW
`ifdef WB_ARB_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*`RF_REG_BITS-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]       req_data,
  input  logic [NUM_REQ*`VEC_WIDTH-1:0]   req_mask,
  input  logic [NUM_REQ*5-1:0]            req_rsv,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [`RF_REG_BITS-1:0]         wb_reg,
  output logic [DATA_W-1:0]               wb_data,
  output logic [`VEC_WIDTH-1:0]           wb_mask,
  output logic                            sb_release,
  output logic [4:0]                      sb_rsv_id
`ifdef WB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]       stat_grants,
  output logic [NUM_REQ*STAT_W-1:0]       stat_stalls
`endif
);

  localparam int IdxW = $clog2(NUM_REQ);

  // Handshake: a transfer happens on a cycle where valid && ready are both high at the clock edge;
  // a producer holds valid and payload steady until it sees ready, and ready never depends on a
  // future cycle. The same rule governs req_* -> arbiter and wb_* -> register file.

  WbReq_t            reqs [NUM_REQ];
  WbReq_t            wbHeld;
  logic              wbValid;
  logic [IdxW-1:0]   ptr;
  logic [IdxW-1:0]   ptrNext;
  logic [NUM_REQ-1:0] grant;
  logic [IdxW-1:0]   gntIdx;
  logic              gntValid;
  logic              load;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i].regIdx = req_reg[i*RegBits +: RegBits];
      reqs[i].data   = req_data[i*DATA_W +: DATA_W];
      reqs[i].mask   = req_mask[i*VecWidth +: VecWidth];
      reqs[i].rsv    = req_rsv[i*RsvBits +: RsvBits];
    end
  end

  rr_arbiter #(.N(NUM_REQ), .IdxW(IdxW)) uRrArbiter (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .gntIdx   (gntIdx),
    .gntValid (gntValid)
  );

  // The output slot can take a new write when empty or when its current write drains this cycle.
  assign load      = !wbValid || wb_ready;
  assign req_ready = grant & {NUM_REQ{load}};
  assign ptrNext   = (gntIdx == IdxW'(NUM_REQ - 1)) ? '0 : gntIdx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wbValid <= 1'b0;
      wbHeld  <= '0;
      ptr     <= '0;
    end else if (load) begin
      wbValid <= gntValid;
      if (gntValid) begin
        wbHeld <= reqs[gntIdx];
        ptr    <= ptrNext;
      end
    end
  end

  assign wb_valid   = wbValid;
  assign wb_reg     = wbHeld.regIdx;
  assign wb_data    = wbHeld.data;
  assign wb_mask    = wbHeld.mask;
  assign sb_release = wbValid && wb_ready;
  assign sb_rsv_id  = wbHeld.rsv;

`ifdef WB_ARB_STATS_EN
  logic [STAT_W-1:0] grantCnt [NUM_REQ];
  logic [STAT_W-1:0] stallCnt [NUM_REQ];

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        grantCnt[i] <= '0;
        stallCnt[i] <= '0;
      end else begin
        if (req_valid[i] && req_ready[i] && !(&grantCnt[i])) grantCnt[i] <= grantCnt[i] + 1'b1;
        if (req_valid[i] && !req_ready[i] && !(&stallCnt[i])) stallCnt[i] <= stallCnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : gStat
    assign stat_grants[g*STAT_W +: STAT_W] = grantCnt[g];
    assign stat_stalls[g*STAT_W +: STAT_W] = stallCnt[g];
  end
`endif

  assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  assert property (@(posedge clk) disable iff (rst)
    (wbValid && !wb_ready) |=> (wbValid && $stable(wbHeld)));

endmodule
